// File: rtl/stack_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_ptr_unit
// Brief    : Main/return stack pointer unit with sticky over/underflow fault
//            FSM. Optional high-water mark via `SP_HIGHWATER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stack_ptr_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] MS_BASE  = 16'h8000,
  parameter logic [ADDR_W-1:0] MS_LIMIT = 16'h7F00,
  parameter logic [ADDR_W-1:0] RS_BASE  = 16'h9000,
  parameter logic [ADDR_W-1:0] RS_LIMIT = 16'h8F00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MSPWrite,
  input  logic              MSPop,
  input  logic              RSPWrite,
  input  logic              RSPop,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] ms_tos,
  output logic [ADDR_W-1:0] ms_nos,
  output logic [ADDR_W-1:0] rs_tos,
  output logic [ADDR_W-1:0] ms_depth,
  output logic [ADDR_W-1:0] rs_depth,
  output logic              fault,
  output logic [3:0]        fault_code,
  output logic [ADDR_W-1:0] ms_hwm
);

  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_msp, w_msp_nxt;
  logic [ADDR_W-1:0] r_rsp, w_rsp_nxt;
  logic [3:0]        r_code, w_code_nxt;

  logic w_ms_ovf, w_ms_unf, w_rs_ovf, w_rs_unf;
  logic w_ms_bad, w_rs_bad;

  assign w_ms_ovf = MSPWrite & ~MSPop & (r_msp == MS_LIMIT);
  assign w_ms_unf = MSPWrite &  MSPop & (r_msp == MS_BASE);
  assign w_rs_ovf = RSPWrite & ~RSPop & (r_rsp == RS_LIMIT);
  assign w_rs_unf = RSPWrite &  RSPop & (r_rsp == RS_BASE);
  assign w_ms_bad = w_ms_ovf | w_ms_unf;
  assign w_rs_bad = w_rs_ovf | w_rs_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_msp   <= MS_BASE;
      r_rsp   <= RS_BASE;
      r_code  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_msp   <= w_msp_nxt;
      r_rsp   <= w_rsp_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Each stack commits independently; a faulting side just holds its pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_msp_nxt   = r_msp;
    w_rsp_nxt   = r_rsp;
    w_code_nxt  = r_code;
    case (r_state)
      ST_RUN: begin
        if (MSPWrite && !w_ms_bad)
          w_msp_nxt = MSPop ? (r_msp + c_one) : (r_msp - c_one);
        if (RSPWrite && !w_rs_bad)
          w_rsp_nxt = RSPop ? (r_rsp + c_one) : (r_rsp - c_one);
        w_code_nxt = r_code | {w_ms_ovf, w_ms_unf, w_rs_ovf, w_rs_unf};
        if (w_ms_bad || w_rs_bad)
          w_state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_code_nxt  = 4'b0000;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign ms_tos     = r_msp;
  assign ms_nos     = r_msp + c_one;
  assign rs_tos     = r_rsp;
  assign ms_depth   = MS_BASE - r_msp;
  assign rs_depth   = RS_BASE - r_rsp;
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = r_code;

`ifdef SP_HIGHWATER_EN
  logic [ADDR_W-1:0] r_hwm;
  logic [ADDR_W-1:0] w_depth_nxt;

  // Compare against the depth that will be visible after this edge.
  assign w_depth_nxt = MS_BASE - w_msp_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_hwm <= '0;
    else if (w_depth_nxt > r_hwm)
      r_hwm <= w_depth_nxt;
  end

  assign ms_hwm = r_hwm;
`else
  assign ms_hwm = '0;
`endif

endmodule
`default_nettype wire
